mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RV32I pipeline, between EX and WB. It latches the EX result and issues one data-memory request per load or store. It aligns and sign-extends load data and presents `rd_addr_mem`/`rd_data_mem`/`load_instr`/`dmem_resp` to the forwarding unit. It registers the completed result into the MEM/WB register.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  EX presents an instruction this cycle
- ex_rd_addr  in  5  destination register (0 = none)
- ex_alu_out  in  32  ALU result / effective address
- ex_rs2_data  in  32  store data
- ex_funct3  in  3  load/store width code
- ex_mem_read / ex_mem_write  in  1 each  load / store (never both)
- mem_ready  out  1  MEM accepts the EX instruction at this edge
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_rmask / dmem_wmask  out  4 each  byte masks; nonzero for exactly one cycle per request
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  read data, valid with dmem_resp
- dmem_resp  in  1  memory response
- rd_addr_mem  out  5  MEM-stage destination for forwarding (0 when invalid or store)
- rd_data_mem  out  32  MEM-stage result for forwarding
- load_instr  out  1  valid load in MEM, not yet completed
- resp_fwd  out  1  dmem_resp qualified by state WAIT (drives forwarding dmem_resp)
- wb_valid, wb_rd_addr[5], wb_rd_data[32]  out  MEM/WB register
- misaligned  out  1  one-cycle pulse when a misaligned access is dropped
- stall_cycles  out  32  count of cycles with mem_valid & ~mem_done

## Operation
- Internal MEM register: mem_valid, rd_addr, alu_out, rs2_data, funct3, read, write.
- Capture: `ex_valid & mem_ready` loads the MEM register at the edge. Otherwise, if mem_done, mem_valid <= 0.
- Definitions:
  - mem_done = mem_valid & (~(read|write) | mis | (state==WAIT & dmem_resp)).
  - mem_ready = ~mem_valid | mem_done.
- Alignment: mis = (width half & addr[0]) | (width word & addr[1:0]!=0).
- FSM:
  - IDLE -> REQ when an aligned load/store is captured.
  - REQ drives the masks and goes to WAIT unconditionally.
  - WAIT holds until dmem_resp. On dmem_resp it goes to REQ if an aligned mem op is captured at the same edge, else to IDLE.
- Masks (off = addr[1:0]):
  - byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
  - Load masks go on rmask, store masks on wmask. The other mask is 0. Both masks are 0 outside REQ.
- Store data: wdata = rs2_data << (8*off).
- Load extract: shifted = dmem_rdata >> (8*off).
  - funct3 000 sext8, 001 sext16, 010 word, 100 zext8, 101 zext16.
  - Other funct3 codes are treated as word.
- Misaligned: no request is issued. The op completes in its first MEM cycle. The `misaligned` pulse is asserted that cycle. A load writes rd_data 0; a store writes nothing.
- rd_data_mem:
  - Load: extracted data in the resp cycle; 0 otherwise.
  - Non-memory op: alu_out.
- rd_addr_mem = mem_valid & ~write ? rd_addr : 0.
- load_instr = mem_valid & read & ~mis.
- MEM/WB register: on mem_done, wb_valid<=1, wb_rd_addr<=(write?0:rd_addr), wb_rd_data<=rd_data_mem. Otherwise wb_valid<=0.
- stall_cycles increments by 1 each cycle mem_valid & ~mem_done; it wraps at 2^32.
- Reset: mem_valid 0, state IDLE, wb_valid 0, wb_rd_addr 0, wb_rd_data 0, stall_cycles 0. All dmem outputs read 0.
- Reset mid-WAIT abandons the request. A later dmem_resp in IDLE is ignored and resp_fwd stays 0.

## Timing
- A non-memory op spends 1 cycle in MEM and reaches WB the next edge.
- Load/store with response latency L≥1 cycles after REQ: MEM occupancy is 1 (REQ) + L cycles. WB is valid the edge after the resp cycle.
- dmem_resp during REQ or IDLE is illegal and ignored.
- The address, data and masks are stable only during REQ; memory must latch them.
- Back-to-back mem ops: the resp cycle of op N and the REQ of op N+1 are consecutive cycles, with no bubble.
- Everything is combinational from the MEM register plus dmem_rdata/dmem_resp. No input-to-output path from the EX ports.

## Test plan
- Aligned lw to x5, addr 0x100, resp 3 cycles after REQ with rdata 0xDEADBEEF:
  - rmask 4'b1111 for exactly one cycle.
  - load_instr 1 for 4 cycles.
  - rd_data_mem 0xDEADBEEF in the resp cycle.
  - wb_rd_data 0xDEADBEEF next edge; stall_cycles +3.
- sb addr 0x203, rs2 0x000000A5: wmask 4'b1000, wdata 0xA5000000, wb_rd_addr 0.
- lb addr 0x1 with rdata 0x00008000 -> 0xFFFFFF80; lbu same -> 0x00000080; lh addr 0x2 with rdata 0x80010000 -> 0xFFFF8001.
- lw addr 0x102: no mask asserted, misaligned pulse, wb_rd_data 0 after 1 cycle.
- lw then add back-to-back:
  - mem_ready 0 until the resp cycle.
  - add captured at the resp edge; its rd_data_mem = alu_out the next cycle.
  - lw resp followed immediately by sw gives REQ with no IDLE cycle.
- rst asserted in WAIT:
  - All outputs return to 0 next cycle.
  - A subsequent dmem_resp produces resp_fwd 0 and wb_valid 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: holds the EX result, issues one
// data-memory request per aligned load/store, and feeds forwarding and MEM/WB.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd_addr,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_rs2_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  output logic        mem_ready,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [4:0]  rd_addr_mem,
  output logic [31:0] rd_data_mem,
  output logic        load_instr,
  output logic        resp_fwd,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_rd_data,
  output logic        misaligned,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // funct3[1:0]: 00 byte, 01 half, anything else is treated as a word access.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic r;
    case (f3[1:0])
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        mem_valid_q;
  logic [4:0]  rd_addr_q;
  logic [31:0] alu_out_q;
  logic [31:0] rs2_data_q;
  logic [2:0]  funct3_q;
  logic        read_q;
  logic        write_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_addr_q;
  logic [31:0] wb_rd_data_q;
  logic [31:0] stall_q;

  logic        mem_op;
  logic        mis;
  logic        resp_wait;
  logic        mem_done;
  logic        capture;
  logic        cap_aligned_mem;
  logic        in_req;
  logic [1:0]  off;
  logic [3:0]  size_mask;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign mem_op    = read_q | write_q;
  assign off       = alu_out_q[1:0];
  assign mis       = mem_valid_q & mem_op & is_misaligned(funct3_q, off);
  assign resp_wait = (state_q == WAIT) & dmem_resp;
  assign mem_done  = mem_valid_q & (~mem_op | mis | resp_wait);
  assign mem_ready = ~mem_valid_q | mem_done;

  assign capture         = ex_valid & mem_ready;
  assign cap_aligned_mem = capture & (ex_mem_read | ex_mem_write)
                         & ~is_misaligned(ex_funct3, ex_alu_out[1:0]);

  // A response is only honoured in WAIT; stray responses elsewhere are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cap_aligned_mem) state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: if (dmem_resp) state_d = cap_aligned_mem ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    size_mask = 4'b1111;
    case (funct3_q[1:0])
      2'b00:   size_mask = 4'b0001 << off;
      2'b01:   size_mask = 4'b0011 << off;
      default: size_mask = 4'b1111;
    endcase
  end

  assign in_req     = (state_q == REQ);
  assign dmem_rmask = (in_req & read_q)  ? size_mask : 4'b0000;
  assign dmem_wmask = (in_req & write_q) ? size_mask : 4'b0000;
  assign dmem_addr  = in_req ? {alu_out_q[31:2], 2'b00} : 32'h0;
  assign dmem_wdata = in_req ? (rs2_data_q << {off, 3'b000}) : 32'h0;

  assign shifted = dmem_rdata >> {off, 3'b000};

  always_comb begin
    load_data = shifted;
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Stores and misaligned loads forward zero; loads only carry data in the resp cycle.
  always_comb begin
    rd_data_mem = 32'h0;
    if (mem_valid_q) begin
      if (!mem_op)
        rd_data_mem = alu_out_q;
      else if (read_q && resp_wait && !mis)
        rd_data_mem = load_data;
    end
  end

  assign rd_addr_mem  = (mem_valid_q & ~write_q) ? rd_addr_q : 5'd0;
  assign load_instr   = mem_valid_q & read_q & ~mis;
  assign resp_fwd     = resp_wait;
  assign misaligned   = mis;
  assign wb_valid     = wb_valid_q;
  assign wb_rd_addr   = wb_rd_addr_q;
  assign wb_rd_data   = wb_rd_data_q;
  assign stall_cycles = stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      rd_addr_q   <= 5'd0;
      alu_out_q   <= 32'h0;
      rs2_data_q  <= 32'h0;
      funct3_q    <= 3'b000;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        mem_valid_q <= 1'b1;
        rd_addr_q   <= ex_rd_addr;
        alu_out_q   <= ex_alu_out;
        rs2_data_q  <= ex_rs2_data;
        funct3_q    <= ex_funct3;
        read_q      <= ex_mem_read;
        write_q     <= ex_mem_write;
      end else if (mem_done) begin
        mem_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q   <= 1'b0;
      wb_rd_addr_q <= 5'd0;
      wb_rd_data_q <= 32'h0;
      stall_q      <= 32'h0;
    end else begin
      wb_valid_q <= mem_done;
      if (mem_done) begin
        wb_rd_addr_q <= write_q ? 5'd0 : rd_addr_q;
        wb_rd_data_q <= rd_data_mem;
      end
      if (mem_valid_q && !mem_done)
        stall_q <= stall_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_rs2_data;
  logic [2:0]  ex_funct3;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        mem_ready;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [4:0]  rd_addr_mem;
  logic [31:0] rd_data_mem;
  logic        load_instr;
  logic        resp_fwd;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        misaligned;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr),
    .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data), .ex_funct3(ex_funct3),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .mem_ready(mem_ready),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .rd_addr_mem(rd_addr_mem), .rd_data_mem(rd_data_mem), .load_instr(load_instr),
    .resp_fwd(resp_fwd), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .wb_rd_data(wb_rd_data), .misaligned(misaligned), .stall_cycles(stall_cycles)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  rdst;
  } op_t;

  function automatic int access_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_mis(input op_t o);
    if (!(o.rd || o.wr)) return 1'b0;
    return (o.addr % access_bytes(o.f3)) != 0;
  endfunction

  function automatic logic [3:0] model_mask(input op_t o);
    int sz;
    int m;
    sz = access_bytes(o.f3);
    m = ((1 << sz) - 1) << int'(o.addr % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int sz;
    logic [31:0] sh;
    logic [31:0] v;
    sz = access_bytes(f3);
    sh = rdata >> (8 * (addr % 4));
    if (sz == 4) return sh;
    v = sh & ((32'd1 << (8 * sz)) - 32'd1);
    if (!f3[2] && v[8 * sz - 1]) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int kind;
    logic [2:0] lf[5];
    lf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    kind = $urandom_range(0, 2);
    o.rd   = (kind == 1);
    o.wr   = (kind == 2);
    o.addr = $urandom;
    o.rs2  = $urandom;
    o.rdst = 5'($urandom);
    if (kind == 0) o.f3 = 3'($urandom);
    else if (kind == 1) o.f3 = lf[$urandom_range(0, 4)];
    else o.f3 = 3'($urandom_range(0, 2));
    if (kind != 0 && $urandom_range(0, 1) == 1)
      o.addr = o.addr & ~32'(access_bytes(o.f3) - 1);
    return o;
  endfunction

  task automatic drive_op(input op_t o);
    ex_valid     = 1'b1;
    ex_mem_read  = o.rd;
    ex_mem_write = o.wr;
    ex_funct3    = o.f3;
    ex_alu_out   = o.addr;
    ex_rs2_data  = o.rs2;
    ex_rd_addr   = o.rdst;
  endtask

  task automatic drive_idle();
    ex_valid     = 1'b0;
    ex_mem_read  = 1'($urandom);
    ex_mem_write = 1'b0;
    ex_funct3    = 3'($urandom);
    ex_alu_out   = $urandom;
    ex_rs2_data  = $urandom;
    ex_rd_addr   = 5'($urandom);
  endtask

  // Runs one op through an empty stage; memory answers lat cycles after REQ.
  task automatic single_op(input op_t o, input int lat, input logic [31:0] rdata,
                           output logic [3:0] rm, output logic [3:0] wm,
                           output logic [31:0] wd, output int mcyc, output logic mis_seen,
                           output logic got, output logic [4:0] wba, output logic [31:0] wbd);
    int req_c;
    rm = 0; wm = 0; wd = 0; mcyc = 0; mis_seen = 0; got = 0; wba = 0; wbd = 0;
    req_c = -1;
    @(posedge clk); #1;
    drive_op(o);
    #1;
    chk("ready_when_empty", 32'(mem_ready), 32'd1);
    @(posedge clk); #1;
    drive_idle();
    for (int c = 0; c < 30 && !got; c++) begin
      dmem_resp  = (req_c >= 0 && c == req_c + lat);
      dmem_rdata = dmem_resp ? rdata : $urandom;
      #1;
      if (dmem_rmask != 0 || dmem_wmask != 0) begin
        mcyc++;
        rm = dmem_rmask; wm = dmem_wmask; wd = dmem_wdata;
        req_c = c;
      end
      if (misaligned) mis_seen = 1'b1;
      if (wb_valid) begin
        got = 1'b1; wba = wb_rd_addr; wbd = wb_rd_data;
      end
      @(posedge clk); #1;
    end
    dmem_resp = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  rdst;
    logic [31:0] rdata;
    logic [3:0]  e_rmask;
    logic [3:0]  e_wmask;
    logic [31:0] e_wdata;
    logic        e_mis;
    logic [4:0]  e_wbaddr;
    logic [31:0] e_wbdata;
    logic        chk_data;
  } vec_t;

  vec_t vecs[17];

  // random-phase state
  op_t         pend[$];
  op_t         cur, h, o;
  logic        cur_v, head_req, waiting, wb_exp, ewd_chk, resp;
  int          cnt, stall_exp;
  logic [31:0] stall0, ewd;
  logic [4:0]  ewa;
  logic [3:0]  e_rm, e_wm;
  logic [31:0] e_rdd, e_addr, e_wd;
  logic        e_ready, e_li, e_mis, e_rf, chk_rdd, memop, al, done;
  logic [4:0]  e_rda;

  // single_op outputs
  logic [3:0]  s_rm, s_wm;
  logic [31:0] s_wd, s_wbd, base;
  int          s_mcyc, li_cyc, rm_cyc;
  logic        s_mis, s_got;
  logic [4:0]  s_wba;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h00000001, 32'h0,        5'd5,  32'h00008000, 4'b0010, 4'b0000, 32'h0,        1'b0, 5'd5,  32'hFFFFFF80, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 3'b100, 32'h00000001, 32'h0,        5'd5,  32'h00008000, 4'b0010, 4'b0000, 32'h0,        1'b0, 5'd5,  32'h00000080, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h00000002, 32'h0,        5'd6,  32'h80010000, 4'b1100, 4'b0000, 32'h0,        1'b0, 5'd6,  32'hFFFF8001, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h00000002, 32'h0,        5'd6,  32'h80010000, 4'b1100, 4'b0000, 32'h0,        1'b0, 5'd6,  32'h00008001, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h00000100, 32'h0,        5'd3,  32'hDEADBEEF, 4'b1111, 4'b0000, 32'h0,        1'b0, 5'd3,  32'hDEADBEEF, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'h00000203, 32'h000000A5, 5'd4,  32'h0,        4'b0000, 4'b1000, 32'hA5000000, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h00000102, 32'h1234ABCD, 5'd4,  32'h0,        4'b0000, 4'b1100, 32'hABCD0000, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h00000010, 32'hCAFEF00D, 5'd4,  32'h0,        4'b0000, 4'b1111, 32'hCAFEF00D, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h00000102, 32'h0,        5'd8,  32'h0,        4'b0000, 4'b0000, 32'h0,        1'b1, 5'd8,  32'h0,        1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'b001, 32'h00000003, 32'h0,        5'd9,  32'h0,        4'b0000, 4'b0000, 32'h0,        1'b1, 5'd9,  32'h0,        1'b1};
    vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h00000201, 32'h11111111, 5'd9,  32'h0,        4'b0000, 4'b0000, 32'h0,        1'b1, 5'd0,  32'h0,        1'b0};
    vecs[11] = '{1'b0, 1'b0, 3'b000, 32'h12345678, 32'h0,        5'd7,  32'h0,        4'b0000, 4'b0000, 32'h0,        1'b0, 5'd7,  32'h12345678, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 3'b010, 32'h00000003, 32'h0,        5'd10, 32'h0,        4'b0000, 4'b0000, 32'h0,        1'b0, 5'd10, 32'h00000003, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 3'b100, 32'h00000003, 32'h0,        5'd11, 32'hF0000000, 4'b1000, 4'b0000, 32'h0,        1'b0, 5'd11, 32'h000000F0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 3'b011, 32'h00000008, 32'h0,        5'd12, 32'h11223344, 4'b1111, 4'b0000, 32'h0,        1'b0, 5'd12, 32'h11223344, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 3'b000, 32'h00000002, 32'h0,        5'd13, 32'h007F0000, 4'b0100, 4'b0000, 32'h0,        1'b0, 5'd13, 32'h0000007F, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 3'b000, 32'h00000001, 32'hFFFFFF5A, 5'd14, 32'h0,        4'b0000, 4'b0010, 32'hFFFF5A00, 1'b0, 5'd0,  32'h0,        1'b0};

    rst = 1'b1;
    dmem_resp = 1'b0;
    dmem_rdata = 32'h0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rd_addr", 32'(wb_rd_addr), 32'd0);
    chk("rst_wb_rd_data", wb_rd_data, 32'd0);
    chk("rst_stall", stall_cycles, 32'd0);
    chk("rst_masks", {24'h0, dmem_rmask, dmem_wmask}, 32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd1);
    chk("rst_load_instr", 32'(load_instr), 32'd0);
    rst = 1'b0;

    // ---------------- vector table ----------------
    foreach (vecs[i]) begin
      o = '{vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].rs2, vecs[i].rdst};
      single_op(o, 1 + (i % 3), vecs[i].rdata, s_rm, s_wm, s_wd, s_mcyc, s_mis, s_got, s_wba, s_wbd);
      $display("vec %0d rd=%0b wr=%0b f3=%03b addr=%08h rm=%04b wm=%04b mis=%0b wb x%0d=%08h",
               i, o.rd, o.wr, o.f3, o.addr, s_rm, s_wm, s_mis, s_wba, s_wbd);
      chk($sformatf("vec%0d_rmask", i), 32'(s_rm), 32'(vecs[i].e_rmask));
      chk($sformatf("vec%0d_wmask", i), 32'(s_wm), 32'(vecs[i].e_wmask));
      if (vecs[i].e_wmask != 0) chk($sformatf("vec%0d_wdata", i), s_wd, vecs[i].e_wdata);
      chk($sformatf("vec%0d_mask_cycles", i), 32'(s_mcyc),
          (vecs[i].e_rmask != 0 || vecs[i].e_wmask != 0) ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_misaligned", i), 32'(s_mis), 32'(vecs[i].e_mis));
      chk($sformatf("vec%0d_wb_seen", i), 32'(s_got), 32'd1);
      chk($sformatf("vec%0d_wb_rd_addr", i), 32'(s_wba), 32'(vecs[i].e_wbaddr));
      if (vecs[i].chk_data) chk($sformatf("vec%0d_wb_rd_data", i), s_wbd, vecs[i].e_wbdata);
    end

    // ---------------- lw x5, 0x100 with response 3 cycles after REQ ----------------
    @(posedge clk); #1;
    base = stall_cycles;
    drive_op('{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5});
    @(posedge clk); #1;
    drive_idle();
    li_cyc = 0; rm_cyc = 0; s_got = 0;
    for (int c = 0; c < 12 && !s_got; c++) begin
      dmem_resp  = (c == 3);
      dmem_rdata = (c == 3) ? 32'hDEADBEEF : $urandom;
      #1;
      if (dmem_rmask != 0) begin
        rm_cyc++;
        chk("lw_rmask", 32'(dmem_rmask), 32'hF);
      end
      if (load_instr) li_cyc++;
      if (c == 3) begin
        chk("lw_rd_data_mem", rd_data_mem, 32'hDEADBEEF);
        chk("lw_resp_fwd", 32'(resp_fwd), 32'd1);
      end
      if (wb_valid) begin
        s_got = 1'b1;
        chk("lw_wb_cycle", 32'(c), 32'd4);
        chk("lw_wb_rd_data", wb_rd_data, 32'hDEADBEEF);
        chk("lw_wb_rd_addr", 32'(wb_rd_addr), 32'd5);
      end
      @(posedge clk); #1;
    end
    dmem_resp = 1'b0;
    chk("lw_rmask_cycles", 32'(rm_cyc), 32'd1);
    chk("lw_load_instr_cycles", 32'(li_cyc), 32'd4);
    chk("lw_stall_delta", stall_cycles - base, 32'd3);
    $display("seq lw x5 0x100 lat3 rmask_cycles=%0d load_instr_cycles=%0d stall+%0d",
             rm_cyc, li_cyc, stall_cycles - base);

    // ---------------- lw then add, back to back ----------------
    @(posedge clk); #1;
    drive_op('{1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd6});
    @(posedge clk); #1;
    drive_op('{1'b0, 1'b0, 3'b000, 32'h000055AA, 32'h0, 5'd9});
    for (int c = 0; c < 3; c++) begin
      dmem_resp  = (c == 2);
      dmem_rdata = 32'h01020304;
      #1;
      chk($sformatf("b2b_add_ready_c%0d", c), 32'(mem_ready), (c == 2) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    dmem_resp = 1'b0;
    drive_idle();
    #1;
    chk("b2b_add_rd_data_mem", rd_data_mem, 32'h000055AA);
    chk("b2b_add_rd_addr_mem", 32'(rd_addr_mem), 32'd9);
    chk("b2b_lw_wb_data", wb_rd_data, 32'h01020304);
    @(posedge clk); #1; #1;
    chk("b2b_add_wb_data", wb_rd_data, 32'h000055AA);
    chk("b2b_add_wb_addr", 32'(wb_rd_addr), 32'd9);
    $display("seq lw x6 then add x9: add forwarded and written back");

    // ---------------- lw then sw: REQ immediately after resp ----------------
    @(posedge clk); #1;
    drive_op('{1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 5'd2});
    @(posedge clk); #1;
    drive_op('{1'b0, 1'b1, 3'b010, 32'h84, 32'h600DF00D, 5'd1});
    for (int c = 0; c < 2; c++) begin
      dmem_resp = (c == 1);
      #1;
      @(posedge clk); #1;
    end
    dmem_resp = 1'b0;
    drive_idle();
    #1;
    chk("b2b_sw_wmask", 32'(dmem_wmask), 32'hF);
    chk("b2b_sw_addr", dmem_addr, 32'h84);
    chk("b2b_sw_wdata", dmem_wdata, 32'h600DF00D);
    @(posedge clk); #1;
    dmem_resp = 1'b1;
    #1;
    chk("b2b_sw_resp_fwd", 32'(resp_fwd), 32'd1);
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    $display("seq lw x2 then sw 0x84: store REQ with no idle cycle");

    // ---------------- randomized traffic vs model ----------------
    repeat (2) @(posedge clk);
    #1;
    stall0 = stall_cycles;
    cur_v = 0; head_req = 0; waiting = 0; wb_exp = 0; cnt = 0; stall_exp = 0;
    ewd_chk = 0; ewd = 0; ewa = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(posedge clk); #1;
      resp = 1'b0;
      if (waiting) begin
        cnt--;
        if (cnt == 0) begin resp = 1'b1; waiting = 1'b0; end
      end
      dmem_resp  = resp;
      dmem_rdata = $urandom;
      if (!cur_v && cyc < 640 && $urandom_range(0, 3) != 0) begin
        cur = rand_op();
        cur_v = 1'b1;
      end
      if (cur_v) drive_op(cur); else drive_idle();
      #1;
      chk("rnd_wb_valid", 32'(wb_valid), 32'(wb_exp));
      if (wb_exp) begin
        chk("rnd_wb_rd_addr", 32'(wb_rd_addr), 32'(ewa));
        if (ewd_chk) chk("rnd_wb_rd_data", wb_rd_data, ewd);
        $display("rnd wb x%0d=%08h", wb_rd_addr, wb_rd_data);
      end
      wb_exp = 1'b0;
      e_rm = 0; e_wm = 0; e_addr = 0; e_wd = 0; e_ready = 1'b1; e_li = 0; e_rda = 0;
      e_rdd = 0; chk_rdd = 1'b1; e_mis = 0; e_rf = 0;
      if (pend.size() > 0) begin
        h = pend[0];
        memop = h.rd || h.wr;
        e_mis = model_mis(h);
        al = memop && !e_mis;
        if (al && !head_req) begin
          head_req = 1'b1;
          waiting = 1'b1;
          cnt = $urandom_range(1, 4);
          stall_exp += cnt;
          if (h.rd) e_rm = model_mask(h); else e_wm = model_mask(h);
          e_addr = h.addr & 32'hFFFF_FFFC;
          e_wd = h.rs2 << (8 * (h.addr % 4));
        end
        done    = !memop || e_mis || (al && resp);
        e_ready = done;
        e_li    = h.rd && !e_mis;
        e_rda   = h.wr ? 5'd0 : h.rdst;
        e_rf    = resp;
        if (!memop) e_rdd = h.addr;
        else if (h.rd && al && resp) e_rdd = model_load(h.f3, h.addr, dmem_rdata);
        chk_rdd = !h.wr;
        if (done) begin
          void'(pend.pop_front());
          head_req = 1'b0;
          wb_exp = 1'b1;
          ewa = e_rda;
          ewd = e_rdd;
          ewd_chk = !h.wr;
        end
      end
      chk("rnd_rmask", 32'(dmem_rmask), 32'(e_rm));
      chk("rnd_wmask", 32'(dmem_wmask), 32'(e_wm));
      if (e_rm != 0 || e_wm != 0) chk("rnd_dmem_addr", dmem_addr, e_addr);
      if (e_wm != 0) chk("rnd_wdata", dmem_wdata, e_wd);
      chk("rnd_mem_ready", 32'(mem_ready), 32'(e_ready));
      chk("rnd_load_instr", 32'(load_instr), 32'(e_li));
      chk("rnd_rd_addr_mem", 32'(rd_addr_mem), 32'(e_rda));
      if (chk_rdd) chk("rnd_rd_data_mem", rd_data_mem, e_rdd);
      chk("rnd_misaligned", 32'(misaligned), 32'(e_mis));
      chk("rnd_resp_fwd", 32'(resp_fwd), 32'(e_rf));
      if (cur_v && e_ready) begin
        pend.push_back(cur);
        cur_v = 1'b0;
      end
    end
    dmem_resp = 1'b0;
    drive_idle();
    chk("rnd_drained", 32'(pend.size()), 32'd0);
    chk("rnd_stall_total", stall_cycles - stall0, 32'(stall_exp));

    // ---------------- reset while waiting for a response ----------------
    @(posedge clk); #1;
    drive_op('{1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd15});
    @(posedge clk); #1;
    drive_idle();
    #1;
    chk("rstw_req_rmask", 32'(dmem_rmask), 32'hF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstw_addr", dmem_addr, 32'd0);
    chk("rstw_masks", {24'h0, dmem_rmask, dmem_wmask}, 32'd0);
    chk("rstw_wdata", dmem_wdata, 32'd0);
    chk("rstw_rd_addr_mem", 32'(rd_addr_mem), 32'd0);
    chk("rstw_rd_data_mem", rd_data_mem, 32'd0);
    chk("rstw_load_instr", 32'(load_instr), 32'd0);
    chk("rstw_wb_valid", 32'(wb_valid), 32'd0);
    chk("rstw_wb_rd_addr", 32'(wb_rd_addr), 32'd0);
    chk("rstw_wb_rd_data", wb_rd_data, 32'd0);
    chk("rstw_stall", stall_cycles, 32'd0);
    chk("rstw_ready", 32'(mem_ready), 32'd1);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hABCD1234;
    #1;
    chk("rstw_late_resp_fwd", 32'(resp_fwd), 32'd0);
    chk("rstw_late_rd_data", rd_data_mem, 32'd0);
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    #1;
    chk("rstw_late_wb_valid", 32'(wb_valid), 32'd0);
    $display("seq reset in WAIT: request abandoned, late response ignored");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
